// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared encodings for the write-back stage
package cpu_types_pkg;

  // Write-back source select; encoding 3 aliases the ALU result.
  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_LOAD    = 2'd1,
    WB_NPC     = 2'd2,
    WB_ALU_ALT = 2'd3
  } wb_sel_e;

  // Load access size; encoding 3 aliases a full word.
  typedef enum logic [1:0] {
    LS_BYTE     = 2'd0,
    LS_HALF     = 2'd1,
    LS_WORD     = 2'd2,
    LS_WORD_ALT = 2'd3
  } lsize_e;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - big-endian sub-word load lane extraction and extension
//
// Purely combinational. Only instantiated when WB_LOAD_EXT_EN is defined.
// Ports:
//   data_i    raw load word
//   lsize_i   access size (lsize_e)
//   lsigned_i sign-extend sub-word results
//   addrlo_i  low address bits; lane 0 is the most significant byte
//   data_o    extracted, extended result
module wb_load_ext
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        lsize_i,
  input  logic              lsigned_i,
  input  logic [1:0]        addrlo_i,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] byte_shift;
  logic [WORD_W-1:0] half_shift;
  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  // Shifting the addressed lane up to the top keeps the big-endian
  // numbering independent of WORD_W.
  assign byte_shift = data_i << {addrlo_i, 3'b000};
  assign half_shift = data_i << {addrlo_i[1], 4'b0000};
  assign byte_lane  = byte_shift[WORD_W-1 -: BYTE_W];
  assign half_lane  = half_shift[WORD_W-1 -: HALF_W];

  always_comb begin
    data_o = data_i;
    case (lsize_e'(lsize_i))
      LS_BYTE: data_o = {{(WORD_W-BYTE_W){lsigned_i & byte_lane[BYTE_W-1]}}, byte_lane};
      LS_HALF: data_o = {{(WORD_W-HALF_W){lsigned_i & half_lane[HALF_W-1]}}, half_lane};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/stage_wb_pipe.sv
// rtl/stage_wb_pipe.sv - MEM/WB pipeline latch with write-back select, halt and retire count
//
// Optional feature macro: WB_LOAD_EXT_EN (sub-word load extraction).
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   stall, flush        hold latch / squash incoming entry (flush wins)
//   valid_in .. halt_in incoming MEM-stage entry fields
//   regWrite_out, regSel_out, wdat_out   register-file write port
//   fwd_valid, fwd_sel, fwd_dat          forwarding copy of the write port
//   halt_out            sticky halted flag
//   retired_cnt         retired instruction count (wraps)
module stage_wb_pipe
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              regWrite_in,
  input  logic [REG_W-1:0]  regSel_in,
  input  logic [1:0]        wbSel_in,
  input  logic [WORD_W-1:0] aluOut_in,
  input  logic [WORD_W-1:0] dmemload_in,
  input  logic [WORD_W-1:0] npc_in,
  input  logic [1:0]        lsize_in,
  input  logic              lsigned_in,
  input  logic [1:0]        addrlo_in,
  input  logic              halt_in,
  output logic              regWrite_out,
  output logic [REG_W-1:0]  regSel_out,
  output logic [WORD_W-1:0] wdat_out,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_sel,
  output logic [WORD_W-1:0] fwd_dat,
  output logic              halt_out,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              valid_q;
  logic              regwrite_q;
  logic [REG_W-1:0]  regsel_q;
  logic [1:0]        wbsel_q;
  logic [WORD_W-1:0] alu_q;
  logic [WORD_W-1:0] load_q;
  logic [WORD_W-1:0] npc_q;
  logic [1:0]        lsize_q;
  logic              lsigned_q;
  logic [1:0]        addrlo_q;
  logic              halt_q;
  logic              halted_q;
  logic              halted_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] load_word;
  logic              capture;

  assign capture = ~stall & ~flush;

  // All fields reset so the write port reads zero while nRST is low.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      regsel_q   <= '0;
      wbsel_q    <= '0;
      alu_q      <= '0;
      load_q     <= '0;
      npc_q      <= '0;
      lsize_q    <= '0;
      lsigned_q  <= 1'b0;
      addrlo_q   <= '0;
      halt_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= valid_in;
      regwrite_q <= regWrite_in;
      regsel_q   <= regSel_in;
      wbsel_q    <= wbSel_in;
      alu_q      <= aluOut_in;
      load_q     <= dmemload_in;
      npc_q      <= npc_in;
      lsize_q    <= lsize_in;
      lsigned_q  <= lsigned_in;
      addrlo_q   <= addrlo_in;
      halt_q     <= halt_in;
    end
  end

  // halt_out rises in the same cycle the halt entry sits in the latch, so
  // the halt entry's own write is suppressed.
  assign halt_out = halted_q | (valid_q & halt_q);
  assign halted_d = halt_out;

  // An entry is counted as it is accepted into the latch, so a stalled
  // entry is counted once regardless of how long it is held.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && valid_in && !halt_in && !halt_out) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(
    .WORD_W(WORD_W)
  ) u_load_ext (
    .data_i   (load_q),
    .lsize_i  (lsize_q),
    .lsigned_i(lsigned_q),
    .addrlo_i (addrlo_q),
    .data_o   (load_word)
  );
`else
  logic unused_load_ctl;
  assign load_word       = load_q;
  assign unused_load_ctl = ^{lsize_q, lsigned_q, addrlo_q};
`endif

  always_comb begin
    wdat_out = alu_q;
    case (wb_sel_e'(wbsel_q))
      WB_LOAD: wdat_out = load_word;
      WB_NPC:  wdat_out = npc_q;
      default: wdat_out = alu_q;
    endcase
  end

  assign regWrite_out = valid_q & regwrite_q & (regsel_q != '0) & ~halt_out;
  assign regSel_out   = regsel_q;
  assign fwd_valid    = regWrite_out;
  assign fwd_sel      = regSel_out;
  assign fwd_dat      = wdat_out;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_stage_wb_pipe.sv
// tb/tb_stage_wb_pipe.sv - randomized and directed checks of stage_wb_pipe against a reference model
module tb_stage_wb_pipe;

  typedef struct {
    bit        valid;
    bit        regwrite;
    bit [4:0]  regsel;
    bit [1:0]  wbsel;
    bit [31:0] alu;
    bit [31:0] dmem;
    bit [31:0] npc;
    bit [1:0]  lsize;
    bit        lsigned;
    bit [1:0]  addrlo;
    bit        halt;
  } ent_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        valid_in = 1'b0, regWrite_in = 1'b0, lsigned_in = 1'b0, halt_in = 1'b0;
  logic [4:0]  regSel_in = '0;
  logic [1:0]  wbSel_in = '0, lsize_in = '0, addrlo_in = '0;
  logic [31:0] aluOut_in = '0, dmemload_in = '0, npc_in = '0;

  logic        regWrite_out, fwd_valid, halt_out;
  logic [4:0]  regSel_out, fwd_sel;
  logic [31:0] wdat_out, fwd_dat, retired_cnt;

  logic        regWrite_out4, fwd_valid4, halt_out4;
  logic [4:0]  regSel_out4, fwd_sel4;
  logic [31:0] wdat_out4, fwd_dat4;
  logic [3:0]  retired_cnt4;

  int checks = 0;
  int errors = 0;

  // Reference model state: the entry currently visible at write-back.
  ent_t        m_e;
  bit          m_valid;
  bit          m_halted;
  int unsigned m_cnt;

  always #5 CLK = ~CLK;

  stage_wb_pipe dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush),
    .valid_in(valid_in), .regWrite_in(regWrite_in), .regSel_in(regSel_in),
    .wbSel_in(wbSel_in), .aluOut_in(aluOut_in), .dmemload_in(dmemload_in),
    .npc_in(npc_in), .lsize_in(lsize_in), .lsigned_in(lsigned_in),
    .addrlo_in(addrlo_in), .halt_in(halt_in),
    .regWrite_out(regWrite_out), .regSel_out(regSel_out), .wdat_out(wdat_out),
    .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_dat(fwd_dat),
    .halt_out(halt_out), .retired_cnt(retired_cnt)
  );

  stage_wb_pipe #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush),
    .valid_in(valid_in), .regWrite_in(regWrite_in), .regSel_in(regSel_in),
    .wbSel_in(wbSel_in), .aluOut_in(aluOut_in), .dmemload_in(dmemload_in),
    .npc_in(npc_in), .lsize_in(lsize_in), .lsigned_in(lsigned_in),
    .addrlo_in(addrlo_in), .halt_in(halt_in),
    .regWrite_out(regWrite_out4), .regSel_out(regSel_out4), .wdat_out(wdat_out4),
    .fwd_valid(fwd_valid4), .fwd_sel(fwd_sel4), .fwd_dat(fwd_dat4),
    .halt_out(halt_out4), .retired_cnt(retired_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] load_val(ent_t e);
`ifdef WB_LOAD_EXT_EN
    int unsigned v;
    if (e.lsize == 2'd0) begin
      v = (e.dmem >> (8 * (3 - int'(e.addrlo)))) & 32'hFF;
      if (e.lsigned && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (e.lsize == 2'd1) begin
      v = (e.dmem >> (e.addrlo[1] ? 0 : 16)) & 32'hFFFF;
      if (e.lsigned && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return e.dmem;
`else
    return e.dmem;
`endif
  endfunction

  function automatic bit [31:0] exp_wdat(ent_t e);
    if (e.wbsel == 2'd1) return load_val(e);
    if (e.wbsel == 2'd2) return e.npc;
    return e.alu;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.valid    = ($urandom_range(0, 3) != 0);
    e.regwrite = ($urandom_range(0, 3) != 0);
    e.regsel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    e.wbsel    = 2'($urandom_range(0, 3));
    e.alu      = $urandom;
    e.dmem     = $urandom;
    e.npc      = $urandom;
    e.lsize    = 2'($urandom_range(0, 3));
    e.lsigned  = 1'($urandom_range(0, 1));
    e.addrlo   = 2'($urandom_range(0, 3));
    e.halt     = ($urandom_range(0, 59) == 0);
    return e;
  endfunction

  function automatic ent_t alu_ent(input bit [4:0] sel, input bit [31:0] val);
    ent_t e;
    e = '{default: 0};
    e.valid = 1'b1; e.regwrite = 1'b1; e.regsel = sel; e.alu = val;
    return e;
  endfunction

  // One clock: drive, advance, update the model, compare all outputs.
  task automatic step(input bit st, input bit fl, input ent_t e);
    bit halt_now, exp_halt, exp_we;
    stall = st; flush = fl;
    valid_in = e.valid; regWrite_in = e.regwrite; regSel_in = e.regsel;
    wbSel_in = e.wbsel; aluOut_in = e.alu; dmemload_in = e.dmem; npc_in = e.npc;
    lsize_in = e.lsize; lsigned_in = e.lsigned; addrlo_in = e.addrlo; halt_in = e.halt;
    @(posedge CLK);
    #1;
    halt_now = m_halted || (m_valid && m_e.halt);
    if (!st && !fl && e.valid && !e.halt && !halt_now) m_cnt++;
    m_halted = halt_now;
    if (fl) m_valid = 1'b0;
    else if (!st) begin m_valid = e.valid; m_e = e; end
    exp_halt = m_halted || (m_valid && m_e.halt);
    exp_we   = m_valid && m_e.regwrite && (m_e.regsel != 0) && !exp_halt;
    chk("regWrite_out", regWrite_out, exp_we);
    chk("fwd_valid", fwd_valid, exp_we);
    chk("halt_out", halt_out, exp_halt);
    chk("retired_cnt", retired_cnt, m_cnt);
    chk("retired_cnt4", retired_cnt4, m_cnt % 16);
    if (m_valid) begin
      chk("regSel_out", regSel_out, m_e.regsel);
      chk("fwd_sel", fwd_sel, m_e.regsel);
      chk("wdat_out", wdat_out, exp_wdat(m_e));
      chk("fwd_dat", fwd_dat, exp_wdat(m_e));
    end
  endtask

  // Asserts nRST between clock edges and checks outputs clear without a clock.
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_regWrite", regWrite_out, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_regSel", regSel_out, 0);
    chk("rst_wdat", wdat_out, 0);
    chk("rst_halt", halt_out, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_cnt4", retired_cnt4, 0);
    m_valid = 0; m_halted = 0; m_cnt = 0; m_e = '{default: 0};
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    ent_t e;
    ent_t idle;
    int unsigned snap;
    idle = '{default: 0};
    m_valid = 0; m_halted = 0; m_cnt = 0; m_e = '{default: 0};

    repeat (2) @(posedge CLK);
    #1;
    chk("init_regWrite", regWrite_out, 0);
    chk("init_wdat", wdat_out, 0);
    chk("init_regSel", regSel_out, 0);
    chk("init_cnt", retired_cnt, 0);
    chk("init_halt", halt_out, 0);
    nRST = 1'b1;

    // ALU write to r3
    step(0, 0, alu_ent(5'd3, 32'h0000_1234));
    chk("alu_we", regWrite_out, 1);
    chk("alu_wdat", wdat_out, 32'h0000_1234);
    chk("alu_cnt", retired_cnt, 1);

    // write to r0 is suppressed but still retires
    step(0, 0, alu_ent(5'd0, 32'hDEAD_BEEF));
    chk("r0_we", regWrite_out, 0);
    chk("r0_cnt", retired_cnt, 2);

    // npc select
    e = alu_ent(5'd31, 32'h1111_1111); e.wbsel = 2'd2; e.npc = 32'h0000_0404;
    step(0, 0, e);
    chk("npc_wdat", wdat_out, 32'h0000_0404);

`ifdef WB_LOAD_EXT_EN
    e = alu_ent(5'd4, 0); e.wbsel = 2'd1; e.dmem = 32'h80FF_7F01;
    e.lsize = 2'd0; e.lsigned = 1'b1; e.addrlo = 2'd0;
    step(0, 0, e);
    chk("ldb_signed", wdat_out, 32'hFFFF_FF80);
    e.lsigned = 1'b0; e.addrlo = 2'd2;
    step(0, 0, e);
    chk("ldb_unsigned", wdat_out, 32'h0000_007F);
`else
    e = alu_ent(5'd4, 0); e.wbsel = 2'd1; e.dmem = 32'h80FF_7F01;
    e.lsize = 2'd0; e.lsigned = 1'b1; e.addrlo = 2'd0;
    step(0, 0, e);
    chk("ld_raw", wdat_out, 32'h80FF_7F01);
`endif

    // stall for 3 cycles holding a valid entry, then flush during stall
    step(0, 0, alu_ent(5'd5, 32'hCAFE_0005));
    snap = m_cnt;
    for (int i = 0; i < 3; i++) step(1, 0, alu_ent(5'd6, $urandom));
    chk("stall_we", regWrite_out, 1);
    chk("stall_wdat", wdat_out, 32'hCAFE_0005);
    chk("stall_sel", regSel_out, 5);
    chk("stall_cnt", retired_cnt, snap);
    step(1, 1, alu_ent(5'd7, 32'h7));
    chk("flush_we", regWrite_out, 0);

    // randomized traffic with occasional halts and resets
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      e = rand_ent();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), e);
    end

    // counter wrap on the 4-bit instance: 17 retirements
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, alu_ent(5'd1, i));
    chk("wrap_cnt4", retired_cnt4, 1);
    chk("wrap_cnt", retired_cnt, 17);

    // halt entry followed by writes
    e = alu_ent(5'd9, 32'h9); e.halt = 1'b1;
    step(0, 0, e);
    chk("halt_set", halt_out, 1);
    chk("halt_no_we", regWrite_out, 0);
    snap = m_cnt;
    for (int i = 0; i < 3; i++) step(0, 0, alu_ent(5'd10, $urandom));
    chk("halt_sticky", halt_out, 1);
    chk("halt_we", regWrite_out, 0);
    chk("halt_cnt", retired_cnt, snap);
    do_reset();

    // reset while a valid entry is held by stall
    step(0, 0, alu_ent(5'd12, 32'h12));
    step(1, 0, idle);
    chk("pre_rst_we", regWrite_out, 1);
    do_reset();
    step(1, 0, alu_ent(5'd13, 32'h13));
    chk("post_rst_we", regWrite_out, 0);
    step(0, 0, idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
